// File: rtl/config_chain_loader_if.sv
// Host/chain-side bundle for the configuration chain loader.
// Readback signals exist only when CFG_READBACK_EN is defined.
interface config_chain_loader_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic              cfg_bit;
    logic              cfg_shift_en;
    logic              cfg_return;
    logic              busy;
    logic              done;
`ifdef CFG_READBACK_EN
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;

    modport master (
        output start, word_data, word_valid, cfg_return,
        input  word_ready, cfg_bit, cfg_shift_en, busy, done, rb_data, rb_valid
    );
    modport slave (
        input  start, word_data, word_valid, cfg_return,
        output word_ready, cfg_bit, cfg_shift_en, busy, done, rb_data, rb_valid
    );
`else
    modport master (
        output start, word_data, word_valid, cfg_return,
        input  word_ready, cfg_bit, cfg_shift_en, busy, done
    );
    modport slave (
        input  start, word_data, word_valid, cfg_return,
        output word_ready, cfg_bit, cfg_shift_en, busy, done
    );
`endif
endinterface

// File: rtl/config_chain_loader.sv
// Serialises host words LSB-first into the config scan chain: exactly CHAIN_LEN shifts, then a done pulse.
// Latency: start->first shift 2 cycles; stalls (shift_en low) when no word is buffered. Readback: CFG_READBACK_EN.
module config_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  i_config_clk,
    input  logic                  i_config_reset,
    config_chain_loader_if.slave  bus
);
    localparam int SB_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WORD_W-1:0] r_sr;
    logic [SB_W-1:0]   r_sr_bits;
    logic              r_sr_valid;
    logic [CNT_W-1:0]  r_bits_left;

    logic              w_shift;
    logic              w_last_of_word;
    logic              w_final;
    logic              w_accept;
    logic              w_word_ready;
    logic              w_busy;
    logic              w_done;
    logic              w_start_load;
    logic [CNT_W-1:0]  w_bits_left_after;
    logic [SB_W-1:0]   w_sr_bits_load;

    assign w_shift           = (r_state == S_LOAD) && r_sr_valid;
    assign w_last_of_word    = w_shift && (r_sr_bits == SB_W'(1));
    assign w_final           = w_shift && (r_bits_left == CNT_W'(1));
    assign w_start_load      = (r_state == S_IDLE) && bus.start;
    assign w_bits_left_after = r_bits_left - CNT_W'(w_shift);
    // Final word keeps only the bits still owed to the chain; its upper bits never shift out.
    assign w_sr_bits_load    = (32'(w_bits_left_after) >= 32'(WORD_W)) ? SB_W'(WORD_W)
                                                                       : SB_W'(w_bits_left_after);
    assign w_accept          = bus.word_valid && w_word_ready;

    always_ff @(posedge i_config_clk or negedge i_config_reset) begin
        if (!i_config_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_word_ready = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_busy       = 1'b1;
                w_word_ready = (!r_sr_valid || w_last_of_word) && (w_bits_left_after != '0);
                if (w_final) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_config_clk or negedge i_config_reset) begin
        if (!i_config_reset) begin
            r_sr        <= '0;
            r_sr_bits   <= '0;
            r_sr_valid  <= 1'b0;
            r_bits_left <= '0;
        end else if (w_start_load) begin
            r_bits_left <= CNT_W'(CHAIN_LEN);
            r_sr_valid  <= 1'b0;
        end else begin
            if (w_shift) begin
                r_bits_left <= r_bits_left - CNT_W'(1);
            end
            // A new word lands in the same cycle the previous word's last bit leaves: no bubble.
            if (w_accept) begin
                r_sr       <= bus.word_data;
                r_sr_bits  <= w_sr_bits_load;
                r_sr_valid <= 1'b1;
            end else if (w_shift) begin
                r_sr      <= r_sr >> 1;
                r_sr_bits <= r_sr_bits - SB_W'(1);
                if (w_last_of_word) begin
                    r_sr_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.cfg_shift_en = w_shift;
    assign bus.cfg_bit      = r_sr[0];
    assign bus.word_ready   = w_word_ready;
    assign bus.busy         = w_busy;
    assign bus.done         = w_done;

`ifdef CFG_READBACK_EN
    logic [WORD_W-1:0] r_rb;
    logic [WORD_W-1:0] r_rb_data;
    logic [SB_W-1:0]   r_rb_cnt;
    logic              r_rb_valid;
    logic [WORD_W-1:0] w_rb_next;

    assign w_rb_next = {bus.cfg_return, r_rb[WORD_W-1:1]};

    always_ff @(posedge i_config_clk or negedge i_config_reset) begin
        if (!i_config_reset) begin
            r_rb       <= '0;
            r_rb_data  <= '0;
            r_rb_cnt   <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (w_start_load) begin
                r_rb     <= '0;
                r_rb_cnt <= '0;
            end else if (w_shift) begin
                r_rb <= w_rb_next;
                if (r_rb_cnt == SB_W'(WORD_W - 1)) begin
                    r_rb_data  <= w_rb_next;
                    r_rb_valid <= 1'b1;
                    r_rb_cnt   <= '0;
                end else if (w_final) begin
                    // Partial tail group sits in the top bits; move it down to bit 0.
                    r_rb_data  <= w_rb_next >> (SB_W'(WORD_W - 1) - r_rb_cnt);
                    r_rb_valid <= 1'b1;
                    r_rb_cnt   <= '0;
                end else begin
                    r_rb_cnt <= r_rb_cnt + SB_W'(1);
                end
            end
        end
    end

    assign bus.rb_data  = r_rb_data;
    assign bus.rb_valid = r_rb_valid;
`else
    logic w_unused_return;
    assign w_unused_return = bus.cfg_return;
`endif
endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader with CHAIN_LEN=40, WORD_W=32 and a behavioural chain model.
module tb_config_chain_loader;
    localparam int WORD_W    = 32;
    localparam int CHAIN_LEN = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    config_chain_loader_if #(.WORD_W(WORD_W)) bus ();

    config_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
        .i_config_clk   (clk),
        .i_config_reset (rst_n),
        .bus            (bus)
    );

    int nvec = 0;
    int nerr = 0;

    // chain[0] is the head cell, chain[CHAIN_LEN-1] the tail
    logic [CHAIN_LEN-1:0] chain = '0;
    assign bus.cfg_return = chain[CHAIN_LEN-1];
    always @(posedge clk) if (bus.cfg_shift_en) chain <= {chain[CHAIN_LEN-2:0], bus.cfg_bit};

    int   g_cyc  = 0;
    int   n_acc  = 0;
    int   n_done = 0;
    int   last_done = -1;
    bit   bit_q[$];
    int   cyc_q[$];
    logic [31:0] rb_q[$];

    always @(negedge clk) begin
        if (bus.cfg_shift_en) begin
            bit_q.push_back(bus.cfg_bit);
            cyc_q.push_back(g_cyc);
        end
        if (bus.word_valid && bus.word_ready) n_acc++;
        if (bus.done) begin
            n_done++;
            last_done = g_cyc;
        end
`ifdef CFG_READBACK_EN
        if (bus.rb_valid) rb_q.push_back(bus.rb_data);
`endif
        g_cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic feed_word(input logic [31:0] w, output bit ok);
        bus.word_data  = w;
        bus.word_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.word_ready) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
    endtask

    task automatic run_load(input logic [31:0] w0, input logic [31:0] w1, input int gap,
                            input int pulse_at, input bit keep_valid,
                            output int t0, output int base, output int acc0, output int done0,
                            output bit tmo);
        bit ok0, ok1, okd;
        base  = bit_q.size();
        acc0  = n_acc;
        done0 = n_done;
        okd   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        t0 = g_cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        fork
            begin
                feed_word(w0, ok0);
                bus.word_valid = 1'b0;
                if (gap > 0) begin
                    for (int i = 0; i < 200; i++) begin
                        @(negedge clk);
                        if (bus.word_ready) break;
                    end
                    repeat (gap) begin @(posedge clk); #1; end
                end
                feed_word(w1, ok1);
                if (!keep_valid) bus.word_valid = 1'b0;
            end
            begin
                if (pulse_at >= 0) begin
                    for (int i = 0; i < 200; i++) begin
                        @(posedge clk); #1;
                        if (bit_q.size() - base >= pulse_at) break;
                    end
                    bus.start = 1'b1;
                    @(posedge clk); #1;
                    bus.start = 1'b0;
                end
            end
        join
        for (int i = 0; i < 300; i++) begin
            if (n_done > done0) begin okd = 1'b1; break; end
            @(posedge clk); #1;
        end
        repeat (5) begin @(posedge clk); #1; end
        bus.word_valid = 1'b0;
        tmo = !(ok0 && ok1 && okd);
    endtask

    function automatic logic [CHAIN_LEN-1:0] got_bits(input int base);
        logic [CHAIN_LEN-1:0] g = '0;
        for (int i = 0; i < CHAIN_LEN; i++)
            if (base + i < bit_q.size()) g[i] = bit_q[base + i];
        return g;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b exp 0", bus.done); end
        nvec++; if (bus.word_ready !== 1'b0) begin nerr++; $display("FAIL reset_ready got %b exp 0", bus.word_ready); end
        nvec++; if (bus.cfg_shift_en !== 1'b0) begin nerr++; $display("FAIL reset_shift_en got %b exp 0", bus.cfg_shift_en); end
        nvec++; if (bus.cfg_bit !== 1'b0) begin nerr++; $display("FAIL reset_cfg_bit got %b exp 0", bus.cfg_bit); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.word_valid = 1'b1;
        @(negedge clk);
        nvec++; if (bus.word_ready !== 1'b0) begin nerr++; $display("FAIL idle_ready got %b exp 0", bus.word_ready); end
        @(posedge clk); #1;
        bus.word_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int t0, base, acc0, done0;
        bit tmo;
        logic [CHAIN_LEN-1:0] exp;
        exp = {8'hC3, 32'hA5A5_0F0F};
        run_load(32'hA5A5_0F0F, 32'h0000_00C3, 0, -1, 1'b0, t0, base, acc0, done0, tmo);
        nvec++; if (tmo) begin nerr++; $display("FAIL b2b_timeout got 1 exp 0"); end
        nvec++; if (bit_q.size() - base != CHAIN_LEN) begin nerr++; $display("FAIL b2b_shift_count got %0d exp %0d", bit_q.size() - base, CHAIN_LEN); end
        nvec++; if (got_bits(base) !== exp) begin nerr++; $display("FAIL b2b_bits got %h exp %h", got_bits(base), exp); end
        nvec++; if (cyc_q[base] - t0 != 2) begin nerr++; $display("FAIL b2b_first_shift got %0d exp 2", cyc_q[base] - t0); end
        nvec++; if (cyc_q[base + CHAIN_LEN - 1] - cyc_q[base] + 1 != CHAIN_LEN) begin nerr++; $display("FAIL b2b_span got %0d exp %0d", cyc_q[base + CHAIN_LEN - 1] - cyc_q[base] + 1, CHAIN_LEN); end
        nvec++; if (last_done - t0 != 42) begin nerr++; $display("FAIL b2b_done_cycle got %0d exp 42", last_done - t0); end
        nvec++; if (n_done - done0 != 1) begin nerr++; $display("FAIL b2b_done_pulses got %0d exp 1", n_done - done0); end
        nvec++; if (n_acc - acc0 != 2) begin nerr++; $display("FAIL b2b_accepts got %0d exp 2", n_acc - acc0); end
        nvec++; if (chain[0] !== exp[CHAIN_LEN-1]) begin nerr++; $display("FAIL b2b_head_cell got %b exp %b", chain[0], exp[CHAIN_LEN-1]); end
        nvec++; if (chain[CHAIN_LEN-1] !== exp[0]) begin nerr++; $display("FAIL b2b_tail_cell got %b exp %b", chain[CHAIN_LEN-1], exp[0]); end
    endtask

    task automatic test_stall();
        int t0, base, acc0, done0;
        bit tmo;
        logic [CHAIN_LEN-1:0] exp;
        exp = {8'hC3, 32'hA5A5_0F0F};
        run_load(32'hA5A5_0F0F, 32'h0000_00C3, 5, -1, 1'b0, t0, base, acc0, done0, tmo);
        nvec++; if (tmo) begin nerr++; $display("FAIL stall_timeout got 1 exp 0"); end
        nvec++; if (bit_q.size() - base != CHAIN_LEN) begin nerr++; $display("FAIL stall_shift_count got %0d exp %0d", bit_q.size() - base, CHAIN_LEN); end
        nvec++; if (got_bits(base) !== exp) begin nerr++; $display("FAIL stall_bits got %h exp %h", got_bits(base), exp); end
        nvec++; if (cyc_q[base + CHAIN_LEN - 1] - cyc_q[base] + 1 != CHAIN_LEN + 5) begin nerr++; $display("FAIL stall_span got %0d exp %0d", cyc_q[base + CHAIN_LEN - 1] - cyc_q[base] + 1, CHAIN_LEN + 5); end
        nvec++; if (last_done - t0 != 47) begin nerr++; $display("FAIL stall_done_cycle got %0d exp 47", last_done - t0); end
        nvec++; if (n_done - done0 != 1) begin nerr++; $display("FAIL stall_done_pulses got %0d exp 1", n_done - done0); end
    endtask

    task automatic test_start_ignored();
        int t0, base, acc0, done0;
        bit tmo;
        logic [CHAIN_LEN-1:0] exp;
        exp = {8'h3C, 32'h1234_5678};
        run_load(32'h1234_5678, 32'h0000_003C, 0, 10, 1'b0, t0, base, acc0, done0, tmo);
        nvec++; if (tmo) begin nerr++; $display("FAIL restart_timeout got 1 exp 0"); end
        nvec++; if (bit_q.size() - base != CHAIN_LEN) begin nerr++; $display("FAIL restart_shift_count got %0d exp %0d", bit_q.size() - base, CHAIN_LEN); end
        nvec++; if (got_bits(base) !== exp) begin nerr++; $display("FAIL restart_bits got %h exp %h", got_bits(base), exp); end
        nvec++; if (last_done - t0 != 42) begin nerr++; $display("FAIL restart_done_cycle got %0d exp 42", last_done - t0); end
        nvec++; if (n_done - done0 != 1) begin nerr++; $display("FAIL restart_done_pulses got %0d exp 1", n_done - done0); end
    endtask

    task automatic test_reset_mid_load();
        int t0, base, acc0, done0;
        bit tmo, ok;
        logic [CHAIN_LEN-1:0] exp;
        base = bit_q.size();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.word_data  = 32'hDEAD_BEEF;
        bus.word_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (bit_q.size() - base >= 20) begin ok = 1'b1; break; end
        end
        nvec++; if (!ok) begin nerr++; $display("FAIL rst_mid_reach_bit20 got 0 exp 1"); end
        @(negedge clk); #1;
        nvec++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL rst_mid_busy_before got %b exp 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL rst_mid_busy got %b exp 0", bus.busy); end
        nvec++; if (bus.cfg_shift_en !== 1'b0) begin nerr++; $display("FAIL rst_mid_shift_en got %b exp 0", bus.cfg_shift_en); end
        nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL rst_mid_done got %b exp 0", bus.done); end
        nvec++; if (bus.word_ready !== 1'b0) begin nerr++; $display("FAIL rst_mid_ready got %b exp 0", bus.word_ready); end
        bus.word_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp = {8'h81, 32'hCAFE_F00D};
        run_load(32'hCAFE_F00D, 32'h0000_0081, 0, -1, 1'b0, t0, base, acc0, done0, tmo);
        nvec++; if (tmo) begin nerr++; $display("FAIL rst_reload_timeout got 1 exp 0"); end
        nvec++; if (bit_q.size() - base != CHAIN_LEN) begin nerr++; $display("FAIL rst_reload_shift_count got %0d exp %0d", bit_q.size() - base, CHAIN_LEN); end
        nvec++; if (got_bits(base) !== exp) begin nerr++; $display("FAIL rst_reload_bits got %h exp %h", got_bits(base), exp); end
        nvec++; if (last_done - t0 != 42) begin nerr++; $display("FAIL rst_reload_done_cycle got %0d exp 42", last_done - t0); end
    endtask

    task automatic test_final_word_trunc();
        int t0, base, acc0, done0, ones;
        bit tmo;
        logic [CHAIN_LEN-1:0] exp, g;
        exp = {8'hFF, 32'h0F0F_A5A5};
        run_load(32'h0F0F_A5A5, 32'hFFFF_FFFF, 0, -1, 1'b1, t0, base, acc0, done0, tmo);
        g = got_bits(base);
        ones = 0;
        for (int i = 0; i < CHAIN_LEN; i++) if (g[i]) ones++;
        nvec++; if (tmo) begin nerr++; $display("FAIL trunc_timeout got 1 exp 0"); end
        nvec++; if (bit_q.size() - base != CHAIN_LEN) begin nerr++; $display("FAIL trunc_shift_count got %0d exp %0d", bit_q.size() - base, CHAIN_LEN); end
        nvec++; if (g !== exp) begin nerr++; $display("FAIL trunc_bits got %h exp %h", g, exp); end
        nvec++; if (ones != 24) begin nerr++; $display("FAIL trunc_ones got %0d exp 24", ones); end
        nvec++; if (n_acc - acc0 != 2) begin nerr++; $display("FAIL trunc_accepts got %0d exp 2", n_acc - acc0); end
    endtask

`ifdef CFG_READBACK_EN
    task automatic test_readback();
        int t0, base, acc0, done0, rb0;
        bit tmo;
        run_load(32'h5A5A_1234, 32'h0000_00C3, 0, -1, 1'b0, t0, base, acc0, done0, tmo);
        rb0 = rb_q.size();
        run_load(32'h0BAD_CAFE, 32'h0000_0077, 0, -1, 1'b0, t0, base, acc0, done0, tmo);
        nvec++; if (tmo) begin nerr++; $display("FAIL rb_timeout got 1 exp 0"); end
        nvec++; if (rb_q.size() - rb0 != 2) begin nerr++; $display("FAIL rb_pulses got %0d exp 2", rb_q.size() - rb0); end
        nvec++; if (rb_q.size() > rb0 && rb_q[rb0] !== 32'h5A5A_1234) begin nerr++; $display("FAIL rb_word0 got %h exp 5a5a1234", rb_q[rb0]); end
        nvec++; if (rb_q.size() > rb0 + 1 && rb_q[rb0 + 1] !== 32'h0000_00C3) begin nerr++; $display("FAIL rb_word1 got %h exp 000000c3", rb_q[rb0 + 1]); end
    endtask
`endif

    initial begin
        bus.start      = 1'b0;
        bus.word_data  = '0;
        bus.word_valid = 1'b0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_start_ignored();
        test_reset_mid_load();
        test_final_word_trunc();
`ifdef CFG_READBACK_EN
        test_readback();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
